// File: rtl/instr_mem_banked.sv
// Banked instruction memory: PROG_SLOTS program slots, a registered fetch port and a
// valid/ready loader. Define IMEM_CLEAR_ON_LOAD_EN to zero the target slot before each load.
module instr_mem_banked #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned PROG_SLOTS = 4,
    localparam int unsigned SLOT_DEPTH = DEPTH / PROG_SLOTS,
    localparam int unsigned SEL_W      = $clog2(PROG_SLOTS),
    localparam int unsigned CNT_W      = $clog2(SLOT_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [SEL_W-1:0]  prog_sel,
    input  logic [ADDR_W-1:0] address,
    input  logic              rd_en,
    output logic [DATA_W-1:0] instrucao,
    output logic              instr_valid,
    input  logic              load_start,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_busy,
    output logic [CNT_W-1:0]  load_count,
    output logic              load_err
);

    localparam int unsigned PHYS_W = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StClear, StLoad} state_e;

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  tgt_q, tgt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
`ifdef IMEM_CLEAR_ON_LOAD_EN
    logic [CNT_W-1:0]  clr_q, clr_d;
`endif

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] instr_q;
    logic              valid_q;

    logic              busy, ready, accept, blocked;
    logic              mem_we;
    logic [PHYS_W-1:0] mem_waddr, fetch_addr;
    logic [DATA_W-1:0] mem_wdata;

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            tgt_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
`ifdef IMEM_CLEAR_ON_LOAD_EN
            clr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            count_q <= count_d;
            err_q   <= err_d;
`ifdef IMEM_CLEAR_ON_LOAD_EN
            clr_q   <= clr_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        count_d = count_q;
        err_d   = err_q;
`ifdef IMEM_CLEAR_ON_LOAD_EN
        clr_d   = clr_q;
`endif
        case (state_q)
            StIdle: begin
                if (load_start) begin
                    tgt_d   = prog_sel;
                    count_d = '0;
                    err_d   = 1'b0;
`ifdef IMEM_CLEAR_ON_LOAD_EN
                    clr_d   = '0;
                    state_d = StClear;
`else
                    state_d = StLoad;
`endif
                end
            end
`ifdef IMEM_CLEAR_ON_LOAD_EN
            StClear: begin
                if (clr_q == CNT_W'(SLOT_DEPTH - 1)) begin
                    state_d = StLoad;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
`endif
            StLoad: begin
                if (accept) begin
                    count_d = count_q + 1'b1;
                    if (load_last) begin
                        state_d = StIdle;
                    end else if (count_q == CNT_W'(SLOT_DEPTH - 1)) begin
                        // Slot full with no end marker: stop rather than spill into next slot
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs and memory write port
    always_comb begin
        busy      = (state_q != StIdle);
        ready     = (state_q == StLoad);
        accept    = ready & load_valid;
        blocked   = busy && (prog_sel == tgt_q);
        mem_we    = accept;
        mem_waddr = PHYS_W'(tgt_q * SLOT_DEPTH + count_q);
        mem_wdata = load_data;
`ifdef IMEM_CLEAR_ON_LOAD_EN
        if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_waddr = PHYS_W'(tgt_q * SLOT_DEPTH + clr_q);
            mem_wdata = '0;
        end
`endif
        mem_we     = mem_we & reset_n;
        fetch_addr = PHYS_W'(prog_sel * SLOT_DEPTH + (address % SLOT_DEPTH));
    end

    // Array is intentionally not reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (rd_en) begin
            if (blocked) begin
                instr_q <= '0;
                valid_q <= 1'b0;
            end else begin
                instr_q <= mem[fetch_addr];
                valid_q <= 1'b1;
            end
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign instrucao   = instr_q;
    assign instr_valid = valid_q;
    assign load_ready  = ready;
    assign load_busy   = busy;
    assign load_count  = count_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_instr_mem_banked.sv
// Directed bench for instr_mem_banked; expectations follow IMEM_CLEAR_ON_LOAD_EN when defined.
module tb_instr_mem_banked;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  prog_sel;
    logic [9:0]  address;
    logic        rd_en;
    logic [31:0] instrucao;
    logic        instr_valid;
    logic        load_start;
    logic [31:0] load_data;
    logic        load_valid;
    logic        load_last;
    logic        load_ready;
    logic        load_busy;
    logic [8:0]  load_count;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [9:0]  addr;
        logic        rd;
        logic [31:0] exp_i;
        logic        exp_v;
    } vec_t;

    vec_t vt [0:17];

    instr_mem_banked dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .prog_sel    (prog_sel),
        .address     (address),
        .rd_en       (rd_en),
        .instrucao   (instrucao),
        .instr_valid (instr_valid),
        .load_start  (load_start),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_busy   (load_busy),
        .load_count  (load_count),
        .load_err    (load_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 400 && load_ready !== 1'b1; k++) tick();
        check("load_ready_timeout", 32'(load_ready), 32'd1);
    endtask

    task automatic load_words(input logic [1:0] slot, input int n, input logic [31:0] base,
                              input bit with_last);
        prog_sel   = slot;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        wait_ready();
        for (int i = 0; i < n; i++) begin
            load_data  = base + 32'(i);
            load_valid = 1'b1;
            load_last  = with_last && (i == n - 1);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            prog_sel = vt[i].sel;
            address  = vt[i].addr;
            rd_en    = vt[i].rd;
            tick();
            check($sformatf("vec%0d_instr", i), instrucao, vt[i].exp_i);
            check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vt[i].exp_v));
        end
        rd_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{2'd1, 10'd0,     1'b1, 32'h8C1F0008, 1'b1};
        vt[1]  = '{2'd1, 10'd1,     1'b1, 32'hA81E0000, 1'b1};
        vt[2]  = '{2'd1, 10'd2,     1'b1, 32'h881F0000, 1'b1};
        vt[3]  = '{2'd1, 10'h101,   1'b1, 32'hA81E0000, 1'b1};
        vt[4]  = '{2'd1, 10'd2,     1'b0, 32'hA81E0000, 1'b0};
        vt[5]  = '{2'd3, 10'd4,     1'b1, 32'h30000004, 1'b1};
        vt[6]  = '{2'd3, 10'd0,     1'b1, 32'h30000000, 1'b1};
        vt[7]  = '{2'd2, 10'd0,     1'b1, 32'h20000000, 1'b1};
        vt[8]  = '{2'd2, 10'd1,     1'b1, 32'h20000001, 1'b1};
        vt[9]  = '{2'd2, 10'd2,     1'b1, 32'h20000002, 1'b1};
        vt[10] = '{2'd1, 10'd0,     1'b1, 32'h8C1F0008, 1'b1};
        vt[11] = '{2'd0, 10'd255,   1'b1, 32'h001000FF, 1'b1};
        vt[12] = '{2'd0, 10'd0,     1'b1, 32'h00100000, 1'b1};
        vt[13] = '{2'd0, 10'h3FF,   1'b1, 32'h001000FF, 1'b1};
        vt[14] = '{2'd3, 10'd0,     1'b1, 32'h40000000, 1'b1};
        vt[15] = '{2'd3, 10'd1,     1'b1, 32'h40000001, 1'b1};
`ifdef IMEM_CLEAR_ON_LOAD_EN
        vt[16] = '{2'd3, 10'd2,     1'b1, 32'h00000000, 1'b1};
        vt[17] = '{2'd3, 10'd4,     1'b1, 32'h00000000, 1'b1};
`else
        vt[16] = '{2'd3, 10'd2,     1'b1, 32'h30000002, 1'b1};
        vt[17] = '{2'd3, 10'd4,     1'b1, 32'h30000004, 1'b1};
`endif

        reset_n    = 1'b0;
        prog_sel   = 2'd0;
        address    = 10'd0;
        rd_en      = 1'b1;
        load_start = 1'b0;
        load_data  = 32'd0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        repeat (3) tick();
        check("rst_instr", instrucao, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_busy",  32'(load_busy), 32'd0);
        check("rst_count", 32'(load_count), 32'd0);
        check("rst_err",   32'(load_err), 32'd0);
        reset_n = 1'b1;
        rd_en   = 1'b0;
        tick();

        // Background program in slot 3, then the basic slot-1 program
        load_words(2'd3, 5, 32'h30000000, 1'b1);
        check("s3_count", 32'(load_count), 32'd5);
        prog_sel   = 2'd1;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("s1_busy_after_start", 32'(load_busy), 32'd1);
        wait_ready();
        load_valid = 1'b1;
        load_data = 32'h8C1F0008; tick();
        load_data = 32'hA81E0000; tick();
        load_data = 32'h881F0000; load_last = 1'b1; tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("s1_busy_done",  32'(load_busy), 32'd0);
        check("s1_ready_done", 32'(load_ready), 32'd0);
        check("s1_count",      32'(load_count), 32'd3);
        check("s1_err",        32'(load_err), 32'd0);
        run_vectors(0, 6);

        // Slot-2 load with stalls, concurrent fetches and an ignored load_start
        prog_sel   = 2'd2;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("s2_busy", 32'(load_busy), 32'd1);
        wait_ready();
        prog_sel = 2'd1; address = 10'd1; rd_en = 1'b1;
        load_valid = 1'b1; load_data = 32'h20000000;
        tick();
        check("iso_other_instr", instrucao, 32'hA81E0000);
        check("iso_other_valid", 32'(instr_valid), 32'd1);
        check("hs_count1", 32'(load_count), 32'd1);
        prog_sel = 2'd2; address = 10'd0; load_valid = 1'b0; load_data = 32'hDEADBEEF;
        tick();
        check("iso_blocked_instr", instrucao, 32'd0);
        check("iso_blocked_valid", 32'(instr_valid), 32'd0);
        check("hs_stall_count", 32'(load_count), 32'd1);
        prog_sel = 2'd0; rd_en = 1'b0; load_start = 1'b1;
        load_valid = 1'b1; load_data = 32'h20000001;
        tick();
        check("hs_count2", 32'(load_count), 32'd2);
        check("hs_busy_after_start", 32'(load_busy), 32'd1);
        load_start = 1'b0; load_last = 1'b1; load_data = 32'h20000002;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        check("hs_count3", 32'(load_count), 32'd3);
        check("hs_busy_done", 32'(load_busy), 32'd0);
        run_vectors(7, 9);

        // Overflow: full slot 0 with no end marker
        load_words(2'd0, 256, 32'h00100000, 1'b0);
        check("ovf_err",   32'(load_err), 32'd1);
        check("ovf_count", 32'(load_count), 32'd256);
        check("ovf_busy",  32'(load_busy), 32'd0);
        run_vectors(10, 13);

        // Reset after 2 of 5 words
        load_words(2'd3, 2, 32'h40000000, 1'b0);
        load_valid = 1'b1; load_data = 32'h40000002; rd_en = 1'b1;
        reset_n = 1'b0;
        tick();
        tick();
        check("mid_rst_instr", instrucao, 32'd0);
        check("mid_rst_count", 32'(load_count), 32'd0);
        reset_n = 1'b1; load_valid = 1'b0; rd_en = 1'b0;
        tick();
        check("mid_rst_busy",  32'(load_busy), 32'd0);
        check("mid_rst_ready", 32'(load_ready), 32'd0);
        check("mid_rst_err",   32'(load_err), 32'd0);
        run_vectors(14, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_banked.md
# instr_mem_banked

Parametrised, runtime-loadable instruction memory for the MIPS datapath. The array is split into PROG_SLOTS equal program slots. The fetch stage reads the slot chosen by `prog_sel` through a registered port. A valid/ready loader FSM writes new programs into any slot, so programs are no longer hard-coded at first clock. It replaces the fixed-program instruction memory between the PC and the decode stage.

## Interface
- DATA_W, 32, instruction width in bits
- ADDR_W, 10, fetch address width in words
- DEPTH, 1024, total words; must be a multiple of PROG_SLOTS
- PROG_SLOTS, 4, number of program slots (power of 2, ≥2)
- SLOT_DEPTH, DEPTH/PROG_SLOTS (derived), words per slot; SEL_W = $clog2(PROG_SLOTS), CNT_W = $clog2(SLOT_DEPTH)+1
- clock  in  1  single clock, all logic on posedge
- reset_n  in  1  reset, synchronous, active-low
- prog_sel  in  SEL_W  slot used for fetch; also sampled at load_start as load target
- address  in  ADDR_W  word address within slot (taken modulo SLOT_DEPTH)
- rd_en  in  1  fetch request
- instrucao  out  DATA_W  registered instruction
- instr_valid  out  1  instrucao holds valid fetched data
- load_start  in  1  begin loading slot prog_sel
- load_data  in  DATA_W  word to write
- load_valid  in  1  load_data valid
- load_last  in  1  marks final word of program
- load_ready  out  1  loader accepts a word this cycle
- load_busy  out  1  loader not IDLE
- load_count  out  CNT_W  words written in current/last load
- load_err  out  1  sticky: slot overflowed without load_last

## Operation
- Physical address = prog_sel*SLOT_DEPTH + (address mod SLOT_DEPTH). The memory array is not reset; contents are undefined until loaded.
- Fetch: when rd_en=1, instrucao ← mem[phys], instr_valid ← 1. When rd_en=0, instrucao holds its value and instr_valid ← 0.
- Fetch blocked: rd_en=1 while load_busy=1 and prog_sel equals the load target slot gives instrucao ← 0 (NOP) and instr_valid ← 0. Fetches from other slots proceed normally during a load.
- FSM states: IDLE, CLEAR (only with macro), LOAD.
- IDLE: load_start=1 captures tgt ← prog_sel, clears load_count and load_err, then goes to CLEAR if the macro is defined, otherwise LOAD.
- LOAD: load_ready=1. A word is accepted when load_valid & load_ready. It writes mem[tgt*SLOT_DEPTH + load_count], then load_count++.
- Leaving LOAD:
  - Accepted word with load_last=1 → IDLE.
  - Accepted word with load_count = SLOT_DEPTH-1 and load_last=0 → load_err ← 1, then IDLE. Writes never spill into the next slot.
- load_start while load_busy=1 is ignored.
- Reset mid-load: FSM returns to IDLE. Words already written remain. Further words are not written.

## Timing
- Reset values: instrucao=0, instr_valid=0, load_ready=0, load_busy=0, load_count=0, load_err=0, FSM=IDLE.
- Fetch latency: 1 cycle, from rd_en sampled at edge N to instrucao/instr_valid valid after edge N.
- load_start at edge N: load_busy=1 and load_ready=1 after edge N (no macro). With the macro, load_ready rises after CLEAR completes.
- Throughput: one accepted load word per cycle.
- Load exit on the final word's edge: load_busy=0 and load_ready=0 in the following cycle.
- A fetch of the word just written, issued after load_busy falls, returns the new data.
- load_count updates on the same edge as the write.

## Configuration
- IMEM_CLEAR_ON_LOAD_EN defined:
  - From IDLE, a load enters CLEAR, which writes 0 to every word of slot tgt, one word per cycle, for SLOT_DEPTH cycles. load_ready=0 and load_busy=1 throughout.
  - After CLEAR the FSM enters LOAD with load_count=0.
  - Unloaded tail words therefore read as NOP.
- Undefined: no CLEAR state. Words beyond the loaded length keep their previous contents.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with rd_en=1 → all outputs 0, FSM IDLE.
- Basic load/fetch: load 3 words (0x8C1F0008, 0xA81E0000, 0x881F0000, last on 3rd) into slot 1. Then prog_sel=1, address=0..2 → those words one cycle after each rd_en, instr_valid=1, load_count=3, load_err=0.
- Slot isolation: during a slot-2 load, fetch slot 1 address 1 → 0xA81E0000 valid. Fetch slot 2 → instrucao=0, instr_valid=0.
- Overflow: stream 256 words into slot 0 without load_last → load_err=1, load_count=256, slot 1 word 0 unchanged.
- Handshake/stall: toggle load_valid 1,0,1,1 while load_ready=1 → exactly 3 writes, at consecutive addresses. load_start issued mid-load is ignored.
- Reset mid-load after 2 of 5 words → IDLE. Words 0–1 present. With IMEM_CLEAR_ON_LOAD_EN, words 2–255 read 0; without it, they keep their old contents.
